fc_output_argmax: RTL and testbench

Final classifier stage, directly downstream of the first fully connected ReLU layer. It consumes the layer's saturated, non-negative W-bit hidden vector and computes NUM_CLASSES output logits with a single time-multiplexed MAC. It tracks the running maximum as each logit completes and reports the winning class index with a level `done`. It trades the parallel-PE area of the hidden layer for NUM_CLASSES·(IN_SIZE+1) cycles of latency.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/mac_unit.sv | 36 +++
 rtl/fc_output_argmax.sv | 162 ++++++++++++++++
 tb/tb_fc_output_argmax.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants and FSM encoding for the fully connected layers
// (hidden ReLU layer and the output argmax stage).
package fc_pkg;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  localparam int FC_W           = 8;
  localparam int FC_IN_SIZE     = 8;
  localparam int FC_NUM_CLASSES = 10;
  localparam int FC_ACC_WIDTH   = acc_width(FC_W, FC_IN_SIZE);
  localparam int FC_IDX_W       = $clog2(FC_NUM_CLASSES);

  localparam int SAT_MAX = (2 ** (FC_W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (FC_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } fc_state_e;

endpackage

// File: rtl/mac_unit.sv
// Signed WxW multiply-accumulate with synchronous clear (priority) and enable.
module mac_unit
  import fc_pkg::*;
#(
  parameter int W         = FC_W,
  parameter int ACC_WIDTH = FC_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [W-1:0]         a,
  input  logic signed [W-1:0]         b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*W-1:0]       prod;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;

  assign prod = (2*W)'(a) * (2*W)'(b);

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_output_argmax.sv
// Output classifier: one time-multiplexed MAC computes each class logit in turn,
// saturates it into logits_flat and tracks the running argmax.
module fc_output_argmax
  import fc_pkg::*;
#(
  parameter int IN_SIZE     = FC_IN_SIZE,
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int W           = FC_W,
  parameter int ACC_WIDTH   = acc_width(W, IN_SIZE),
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [W*IN_SIZE-1:0]             in_vector_flat,
  input  logic [W*NUM_CLASSES*IN_SIZE-1:0] weights_flat,
  input  logic [W*NUM_CLASSES-1:0]         biases_flat,
  output logic [W*NUM_CLASSES-1:0]         logits_flat,
  output logic [IDX_W-1:0]                 class_idx,
  output logic signed [ACC_WIDTH-1:0]      max_logit,
  output logic                             busy,
  output logic                             done
);

  localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [KW-1:0]    K_LAST = KW'(IN_SIZE - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2 ** (W - 1)));

  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_HI) return SAT_HI[W-1:0];
    if (v < SAT_LO) return SAT_LO[W-1:0];
    return v[W-1:0];
  endfunction

  fc_state_e state_d, state_q;
  logic [IDX_W-1:0] c_d, c_q;
  logic [KW-1:0]    k_d, k_q;

  logic signed [W-1:0] x_in [IN_SIZE];
  logic signed [W-1:0] w_in [NUM_CLASSES][IN_SIZE];
  logic signed [W-1:0] b_in [NUM_CLASSES];
  logic signed [W-1:0] x_d [IN_SIZE], x_q [IN_SIZE];
  logic signed [W-1:0] w_d [NUM_CLASSES][IN_SIZE], w_q [NUM_CLASSES][IN_SIZE];
  logic signed [W-1:0] b_d [NUM_CLASSES], b_q [NUM_CLASSES];
  logic signed [W-1:0] logits_d [NUM_CLASSES], logits_q [NUM_CLASSES];

  logic [IDX_W-1:0]            class_idx_d, class_idx_q;
  logic signed [ACC_WIDTH-1:0] max_logit_d, max_logit_q;
  logic signed [ACC_WIDTH-1:0] acc, logit;
  logic                        acc_clr, acc_en;

  for (genvar i = 0; i < IN_SIZE; i++) begin : g_x
    assign x_in[i] = in_vector_flat[i*W +: W];
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    assign b_in[c] = biases_flat[c*W +: W];
    assign logits_flat[c*W +: W] = logits_q[c];
    for (genvar k = 0; k < IN_SIZE; k++) begin : g_w
      assign w_in[c][k] = weights_flat[(c*IN_SIZE + k)*W +: W];
    end
  end

  mac_unit #(
    .W        (W),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .clr(acc_clr | reset),
    .en (acc_en),
    .a  (x_q[k_q]),
    .b  (w_q[c_q][k_q]),
    .acc(acc)
  );

  assign logit = acc + ACC_WIDTH'(b_q[c_q]);

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    k_d         = k_q;
    x_d         = x_q;
    w_d         = w_q;
    b_d         = b_q;
    logits_d    = logits_q;
    class_idx_d = class_idx_q;
    max_logit_d = max_logit_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_d     = x_in;
          w_d     = w_in;
          b_d     = b_in;
          c_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (k_q == K_LAST) begin
          state_d = ST_CMP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_CMP: begin
        logits_d[c_q] = sat_w(logit);
        // Strict compare: on a tie the earlier (lower) class keeps the win.
        if (c_q == '0 || logit > max_logit_q) begin
          max_logit_d = logit;
          class_idx_d = c_q;
        end
        acc_clr = 1'b1;
        k_d     = '0;
        if (c_q == C_LAST) begin
          state_d = ST_DONE;
        end else begin
          c_d     = c_q + IDX_W'(1);
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      c_q         <= '0;
      k_q         <= '0;
      logits_q    <= '{default: '0};
      class_idx_q <= '0;
      max_logit_q <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      k_q         <= k_d;
      logits_q    <= logits_d;
      class_idx_q <= class_idx_d;
      max_logit_q <= max_logit_d;
    end
  end

  // Operand copies are pure data; they are only consumed after a start loads them.
  always_ff @(posedge clk) begin
    x_q <= x_d;
    w_q <= w_d;
    b_q <= b_d;
  end

  assign class_idx = class_idx_q;
  assign max_logit = max_logit_q;
  assign busy      = (state_q == ST_MAC) || (state_q == ST_CMP);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fc_output_argmax.sv
// Directed table-driven bench for fc_output_argmax plus restart, reset and
// input-isolation sequences.
module tb_fc_output_argmax;

  localparam int IN = 8;
  localparam int NC = 10;
  localparam int W  = 8;
  localparam int AW = 2 * W + $clog2(IN) + 1;
  localparam int IW = $clog2(NC);
  localparam int LAT = NC * (IN + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [W*IN-1:0]        in_vector_flat;
  logic [W*NC*IN-1:0]     weights_flat;
  logic [W*NC-1:0]        biases_flat;
  logic [W*NC-1:0]        logits_flat;
  logic [IW-1:0]          class_idx;
  logic signed [AW-1:0]   max_logit;
  logic                   busy;
  logic                   done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x_val;
    int w_row    [NC];
    int b        [NC];
    int exp_slot [NC];
    int exp_idx;
    int exp_max;
  } vec_t;

  vec_t vecs [4];

  fc_output_argmax #(
    .IN_SIZE    (IN),
    .NUM_CLASSES(NC),
    .W          (W),
    .ACC_WIDTH  (AW),
    .IDX_W      (IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_vector_flat(in_vector_flat),
    .weights_flat  (weights_flat),
    .biases_flat   (biases_flat),
    .logits_flat   (logits_flat),
    .class_idx     (class_idx),
    .max_logit     (max_logit),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int vi);
    for (int k = 0; k < IN; k++) in_vector_flat[k*W +: W] = W'(vecs[vi].x_val);
    for (int c = 0; c < NC; c++) begin
      biases_flat[c*W +: W] = W'(vecs[vi].b[c]);
      for (int k = 0; k < IN; k++) weights_flat[(c*IN + k)*W +: W] = W'(vecs[vi].w_row[c]);
    end
  endtask

  task automatic check_result(input int vi, input string tag);
    for (int c = 0; c < NC; c++)
      chk($sformatf("%s slot%0d", tag, c), longint'($signed(logits_flat[c*W +: W])),
          vecs[vi].exp_slot[c]);
    chk({tag, " class_idx"}, longint'(class_idx), vecs[vi].exp_idx);
    chk({tag, " max_logit"}, longint'($signed(max_logit)), vecs[vi].exp_max);
    chk({tag, " busy at done"}, longint'(busy), 0);
  endtask

  // Starts vector vi and waits (bounded) for done. Optional extra start pulse
  // at cycle mid_start, per-cycle input scrambling, and a mid-run slot peek.
  task automatic run_vec(input int vi, input int mid_start, input bit scramble,
                         input int peek_cycle, input int peek_slot, input int peek_exp,
                         input string tag);
    int lat;
    @(negedge clk);
    drive_vec(vi);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " busy after start"}, longint'(busy), 1);
    chk({tag, " done after start"}, longint'(done), 0);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (scramble) begin
        in_vector_flat = {$urandom, $urandom};
        for (int j = 0; j < (W*NC*IN)/32; j++) weights_flat[j*32 +: 32] = $urandom;
        biases_flat = (W*NC)'({$urandom, $urandom, $urandom});
      end
      start = (n == mid_start);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == peek_cycle)
        chk($sformatf("%s mid-run slot%0d", tag, peek_slot),
            longint'($signed(logits_flat[peek_slot*W +: W])), peek_exp);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, LAT);
  endtask

  initial begin
    int seen;

    // x=1, row c weights=c, biases 0 -> logit 8c
    vecs[0].x_val = 1;
    for (int c = 0; c < NC; c++) begin
      vecs[0].w_row[c] = c;  vecs[0].b[c] = 0;  vecs[0].exp_slot[c] = 8 * c;
    end
    vecs[0].exp_idx = 9;  vecs[0].exp_max = 72;

    // x=127, rows 3 and 7 = 127: 8*127*127 = 129032 saturates; tie -> lower index
    vecs[1].x_val = 127;
    for (int c = 0; c < NC; c++) begin
      vecs[1].w_row[c] = (c == 3 || c == 7) ? 127 : 0;
      vecs[1].b[c] = 0;
      vecs[1].exp_slot[c] = (c == 3 || c == 7) ? 127 : 0;
    end
    vecs[1].exp_idx = 3;  vecs[1].exp_max = 129032;

    // x=2, weights -1, bias -c -> logit -16-c
    vecs[2].x_val = 2;
    for (int c = 0; c < NC; c++) begin
      vecs[2].w_row[c] = -1;  vecs[2].b[c] = -c;  vecs[2].exp_slot[c] = -16 - c;
    end
    vecs[2].exp_idx = 0;  vecs[2].exp_max = -16;

    // same, but bias 5 = -120 -> logit -136 clamps to -128
    vecs[3] = vecs[2];
    vecs[3].b[5] = -120;
    vecs[3].exp_slot[5] = -128;

    reset = 1'b1;
    start = 1'b0;
    in_vector_flat = '0;
    weights_flat = '0;
    biases_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset logits nonzero", longint'(logits_flat != '0), 0);
    chk("reset class_idx", longint'(class_idx), 0);
    chk("reset max_logit", longint'($signed(max_logit)), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    reset = 1'b0;

    // Each run after the first restarts straight from DONE.
    for (int i = 0; i < 4; i++) begin
      run_vec(i, -1, 1'b0, -1, 0, 0, $sformatf("vec%0d", i));
      check_result(i, $sformatf("vec%0d", i));
    end

    // Ignored mid-run start; slot 5 still holds vec3's -128 at cycle 20.
    run_vec(0, 40, 1'b0, 20, 5, -128, "midstart");
    check_result(0, "midstart");

    // Inputs scrambled every cycle after start.
    run_vec(1, -1, 1'b1, -1, 0, 0, "isolate");
    check_result(1, "isolate");

    // Reset (with a simultaneous start) at cycle 50 of a run.
    @(negedge clk);
    drive_vec(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    chk("abort logits nonzero", longint'(logits_flat != '0), 0);
    chk("abort class_idx", longint'(class_idx), 0);
    chk("abort max_logit", longint'($signed(max_logit)), 0);
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    chk("abort no activity", seen, 0);

    run_vec(2, -1, 1'b0, -1, 0, 0, "after-reset");
    check_result(2, "after-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
